// File: rtl/time_entry_if.sv
// Keypad/counter-chain bus for the time-entry stage.
//  key_valid, key_code, running : into the block (from keypad / counter chain)
//  sec_ones..min_tens           : BCD preset digits to the counter chain
//  loadn                        : active-low one-cycle preset strobe
//  digit_count, entry_err       : entry status
interface time_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       running;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       loadn;
  logic [2:0] digit_count;
  logic       entry_err;

  modport master (output key_valid, key_code, running,
                  input  sec_ones, sec_tens, min_ones, min_tens, loadn, digit_count, entry_err);
  modport slave  (input  key_valid, key_code, running,
                  output sec_ones, sec_tens, min_ones, min_tens, loadn, digit_count, entry_err);
endinterface

// File: rtl/time_entry.sv
// Keypad time entry (MM:SS) for the microwave's BCD down-counter chain.
// Synchronises and debounces the keypad, shifts digits in from the right,
// validates on START and fires a one-cycle active-low load strobe.
//  clk, rstn : clock, async active-low reset
//  bus       : time_entry_if.slave (key inputs, running, digit/status outputs)
module time_entry #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rstn,
  time_entry_if.slave  bus
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, ARMED, RUN} state_t;

  // input synchroniser
  logic [SYNC_STAGES-1:0]      v_sync;
  logic [SYNC_STAGES-1:0][3:0] c_sync;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_sync <= '0;
      c_sync <= '0;
    end else begin
      v_sync <= {v_sync[SYNC_STAGES-2:0], bus.key_valid};
      c_sync <= {c_sync[SYNC_STAGES-2:0], bus.key_code};
    end
  end

  wire       sv = v_sync[SYNC_STAGES-1];
  wire [3:0] sc = c_sync[SYNC_STAGES-1];

  // debounce: counter runs only while the synced level disagrees with the
  // accepted level; any agreeing sample restarts it.
  logic          deb_lvl, ev;
  logic [CW-1:0] deb_cnt;
  logic [3:0]    ev_code;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
      ev      <= 1'b0;
      ev_code <= '0;
    end else begin
      ev <= 1'b0;
      if (sv != deb_lvl) begin
        if (deb_cnt == CW'(DEBOUNCE_CYCLES-1)) begin
          deb_lvl <= sv;
          deb_cnt <= '0;
          ev      <= sv;          // press only; release is silent
          if (sv) ev_code <= sc;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // entry FSM; dig[3]=min_tens .. dig[0]=sec_ones
  state_t          state, state_n;
  logic [3:0][3:0] dig, dig_n;
  logic [2:0]      cnt, cnt_n;
  logic            err_n, loadn_q, err_q;

  always_comb begin
    state_n = state;
    dig_n   = dig;
    cnt_n   = cnt;
    err_n   = 1'b0;
    if (ev && ev_code == 4'hA && state != LOAD) begin
      state_n = IDLE;
      dig_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, ENTRY: if (ev) begin
          if (ev_code <= 4'd9) begin
            if (cnt != 3'd4) begin
              dig_n   = {dig[2:0], ev_code};
              cnt_n   = cnt + 3'd1;
              state_n = ENTRY;
            end
          end else if (ev_code == 4'hB) begin
            if (state == IDLE || dig[1] > 4'd5 || dig == '0) err_n = 1'b1;
            else                                              state_n = LOAD;
          end
        end
        LOAD:  state_n = ARMED;
        ARMED: if (bus.running) state_n = RUN;
        RUN:   if (!bus.running) begin
          state_n = IDLE;
          dig_n   = '0;
          cnt_n   = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // loadn/entry_err are registered from next-state so the strobe is glitch-free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      dig     <= '0;
      cnt     <= '0;
      loadn_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      dig     <= dig_n;
      cnt     <= cnt_n;
      loadn_q <= (state_n != LOAD);
      err_q   <= err_n;
    end
  end

  assign bus.min_tens    = dig[3];
  assign bus.min_ones    = dig[2];
  assign bus.sec_tens    = dig[1];
  assign bus.sec_ones    = dig[0];
  assign bus.digit_count = cnt;
  assign bus.loadn       = loadn_q;
  assign bus.entry_err   = err_q;
endmodule
